// File: rtl/sprite_line_engine_if.sv
// Pixel/scan/ROM bus between the video timing + OAM side and the sprite engine.
interface sprite_line_engine_if #(
  parameter int OAM_DEPTH = 16
);
  logic                   video_on;
  logic [9:0]             x;
  logic [9:0]             y;
  logic                   line_start;
  logic [9:0]             line_y;
  logic [32*OAM_DEPTH-1:0] oam_data;
  logic [9:0]             rom_x;
  logic [9:0]             rom_y;
  logic [11:0]            rom_color;
  logic                   sprite_on;
  logic [11:0]            color;
  logic                   line_overflow;
  logic                   scan_busy;

  modport master (
    output video_on, x, y, line_start, line_y, oam_data, rom_color,
    input  rom_x, rom_y, sprite_on, color, line_overflow, scan_busy
  );

  modport slave (
    input  video_on, x, y, line_start, line_y, oam_data, rom_color,
    output rom_x, rom_y, sprite_on, color, line_overflow, scan_busy
  );
endinterface

// File: rtl/sprite_line_engine.sv
// Scanline sprite engine: hblank OAM scan into per-line slots, then a
// 3-clock pixel pipeline against an external synchronous sprite ROM.

module sprite_slot_match #(
  parameter int TILE_WIDTH = 8
) (
  input  logic       valid,
  input  logic [9:0] pos_x,
  input  logic       hflip,
  input  logic [2:0] tile_u,
  input  logic [9:0] x,
  output logic       hit,
  output logic [9:0] rom_x
);
  logic [10:0] dx;
  logic [9:0]  dx_m;

  // bit 10 set means x is left of the sprite; there is no wrap past 1023
  assign dx    = {1'b0, x} - {1'b0, pos_x};
  assign hit   = valid && !dx[10] && (dx < 11'(TILE_WIDTH));
  assign dx_m  = hflip ? 10'(TILE_WIDTH - 1) - dx[9:0] : dx[9:0];
  assign rom_x = {7'd0, tile_u} * 10'(TILE_WIDTH) + dx_m;
endmodule

module sprite_line_engine #(
  parameter int          OAM_DEPTH    = 16,
  parameter int          MAX_PER_LINE = 4,
  parameter int          TILE_WIDTH   = 8,
  parameter int          TILE_HEIGHT  = 8,
  parameter logic [11:0] TRANSPARENT  = 12'hF0F
) (
  input logic                  clk,
  input logic                  reset,
  sprite_line_engine_if.slave  bus
);
  localparam int IDX_W  = (OAM_DEPTH > 1) ? $clog2(OAM_DEPTH) : 1;
  localparam int CNT_W  = $clog2(MAX_PER_LINE + 1);
  localparam int SEL_W  = $clog2(32 * OAM_DEPTH);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] pos_x;
    logic       hflip;
    logic [2:0] tile_u;
    logic [9:0] row;
  } slot_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            index_q, index_d;
  logic [9:0]                  line_y_q, line_y_d;
  slot_t [MAX_PER_LINE-1:0]    slot_q, slot_d;
  logic [CNT_W-1:0]            slot_cnt_q, slot_cnt_d;
  logic                        ovf_acc_q, ovf_acc_d;
  logic                        line_overflow_q, line_overflow_d;
  logic [9:0]                  rom_x_q, rom_x_d, rom_y_q, rom_y_d;
  logic [STAGES:1]             vld_pipe_q, vld_pipe_d;
  logic                        sprite_on_q, sprite_on_d;
  logic [11:0]                 color_q, color_d;

  logic                        ready, last_idx, ent_hit, pix_match, win_hit;
  logic [SEL_W-1:0]            ent_base;
  logic [28:0]                 ent;
  logic [10:0]                 dy;
  logic [9:0]                  row_off, ent_row, win_x, win_y;
  logic [MAX_PER_LINE-1:0]     slot_hit;
  logic [MAX_PER_LINE-1:0][9:0] slot_rom_x;
  logic                        unused_y;

  assign unused_y = ^bus.y;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign last_idx = (index_q == IDX_W'(OAM_DEPTH - 1));

  always_comb begin
    state_d = state_q;
    if (bus.line_start)               state_d = SCAN;
    else if (state_q == SCAN && last_idx) state_d = READY;
  end

  always_comb begin
    bus.scan_busy = (state_q == SCAN);
    ready         = (state_q == READY);
  end

  // ---------------- OAM scan ----------------
  assign ent_base = SEL_W'({index_q, 5'b0});
  assign ent      = bus.oam_data[ent_base +: 29];
  assign dy       = {1'b0, line_y_q} - {1'b0, ent[17:8]};
  assign ent_hit  = ent[28] && !dy[10] && (dy < 11'(TILE_HEIGHT));
  assign row_off  = ent[6] ? 10'(TILE_HEIGHT - 1) - dy[9:0] : dy[9:0];
  assign ent_row  = {7'd0, ent[2:0]} * 10'(TILE_HEIGHT) + row_off;

  always_comb begin
    line_y_d        = line_y_q;
    index_d         = index_q;
    slot_d          = slot_q;
    slot_cnt_d      = slot_cnt_q;
    ovf_acc_d       = ovf_acc_q;
    line_overflow_d = line_overflow_q;
    if (bus.line_start) begin
      line_y_d   = bus.line_y;
      index_d    = '0;
      slot_cnt_d = '0;
      ovf_acc_d  = 1'b0;
      for (int s = 0; s < MAX_PER_LINE; s++) slot_d[s].valid = 1'b0;
    end else if (state_q == SCAN) begin
      index_d = index_q + 1'b1;
      if (ent_hit) begin
        if (slot_cnt_q == CNT_W'(MAX_PER_LINE)) begin
          ovf_acc_d = 1'b1;
        end else begin
          for (int s = 0; s < MAX_PER_LINE; s++) begin
            if (CNT_W'(s) == slot_cnt_q) begin
              slot_d[s].valid  = 1'b1;
              slot_d[s].pos_x  = ent[27:18];
              slot_d[s].hflip  = ent[7];
              slot_d[s].tile_u = ent[5:3];
              slot_d[s].row    = ent_row;
            end
          end
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end
      // an aborted scan never reaches here, so the flag keeps the last full scan
      if (last_idx) line_overflow_d = ovf_acc_d;
    end
  end

  // ---------------- pixel pipeline ----------------
  for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_slot
    sprite_slot_match #(.TILE_WIDTH(TILE_WIDTH)) u_match (
      .valid  (slot_q[s].valid),
      .pos_x  (slot_q[s].pos_x),
      .hflip  (slot_q[s].hflip),
      .tile_u (slot_q[s].tile_u),
      .x      (bus.x),
      .hit    (slot_hit[s]),
      .rom_x  (slot_rom_x[s])
    );
  end

  // lowest slot wins; a transparent winner masks the others later in the pipe
  always_comb begin
    win_hit = 1'b0;
    win_x   = '0;
    win_y   = '0;
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      if (slot_hit[s]) begin
        win_hit = 1'b1;
        win_x   = slot_rom_x[s];
        win_y   = slot_q[s].row;
      end
    end
  end

  always_comb begin
    pix_match   = ready && bus.video_on && win_hit;
    rom_x_d     = pix_match ? win_x : rom_x_q;
    rom_y_d     = pix_match ? win_y : rom_y_q;
    vld_pipe_d  = {vld_pipe_q[1], pix_match};
    sprite_on_d = vld_pipe_q[2] && (bus.rom_color != TRANSPARENT);
    color_d     = sprite_on_d ? bus.rom_color : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_q         <= '0;
      line_y_q        <= '0;
      slot_q          <= '0;
      slot_cnt_q      <= '0;
      ovf_acc_q       <= 1'b0;
      line_overflow_q <= 1'b0;
      rom_x_q         <= '0;
      rom_y_q         <= '0;
      vld_pipe_q      <= '0;
      sprite_on_q     <= 1'b0;
      color_q         <= '0;
    end else begin
      index_q         <= index_d;
      line_y_q        <= line_y_d;
      slot_q          <= slot_d;
      slot_cnt_q      <= slot_cnt_d;
      ovf_acc_q       <= ovf_acc_d;
      line_overflow_q <= line_overflow_d;
      rom_x_q         <= rom_x_d;
      rom_y_q         <= rom_y_d;
      vld_pipe_q      <= vld_pipe_d;
      sprite_on_q     <= sprite_on_d;
      color_q         <= color_d;
    end
  end

  assign bus.rom_x         = rom_x_q;
  assign bus.rom_y         = rom_y_q;
  assign bus.sprite_on     = sprite_on_q;
  assign bus.color         = color_q;
  assign bus.line_overflow = line_overflow_q;
endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine with a synchronous sprite ROM model.
module tb_sprite_line_engine;
  localparam int OAM_DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  logic       trans_en = 1'b0;
  logic [9:0] trans_rx = '0, trans_ry = '0;

  logic        exp_m   [64];
  logic [9:0]  exp_rx  [64];
  logic [9:0]  exp_ry  [64];
  logic        exp_on  [64];
  logic [11:0] exp_col [64];

  always #5 clk = ~clk;

  sprite_line_engine_if #(.OAM_DEPTH(OAM_DEPTH)) bus ();

  sprite_line_engine #(
    .OAM_DEPTH(OAM_DEPTH), .MAX_PER_LINE(4), .TILE_WIDTH(8), .TILE_HEIGHT(8),
    .TRANSPARENT(12'hF0F)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  function automatic logic [11:0] rom_fn(input logic [9:0] rx, input logic [9:0] ry);
    if (trans_en && rx == trans_rx && ry == trans_ry) return 12'hF0F;
    return {2'b01, ry[4:0] ^ ry[9:5], rx[4:0] ^ rx[9:5]};
  endfunction

  always @(posedge clk) bus.rom_color <= rom_fn(bus.rom_x, bus.rom_y);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic en, input int px, input int py,
                                     input logic hf, input logic vf, input int tu, input int tv);
    return {3'b0, en, 10'(px), 10'(py), hf, vf, 3'(tu), 3'(tv)};
  endfunction

  task automatic set_oam(input int i, input logic [31:0] v);
    bus.oam_data[32*i +: 32] = v;
  endtask

  task automatic set_exp(input int k, input logic m, input int rx, input int ry);
    logic [11:0] c;
    exp_m[k]  = m;
    exp_rx[k] = 10'(rx);
    exp_ry[k] = 10'(ry);
    c = rom_fn(10'(rx), 10'(ry));
    exp_on[k]  = m && (c != 12'hF0F);
    exp_col[k] = exp_on[k] ? c : 12'h000;
  endtask

  task automatic pulse_start(input logic [9:0] ly);
    @(posedge clk); #1;
    bus.line_start = 1'b1;
    bus.line_y     = ly;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
  endtask

  // counts scan_busy cycles from the cycle after line_start; bounded
  task automatic wait_scan;
    int cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.scan_busy) break;
      cnt++;
      @(posedge clk); #1;
    end
    check("busy_len", cnt, OAM_DEPTH);
  endtask

  // x changes just after an edge; rom addr checked one clock later, pixel three
  task automatic run_px(input logic [9:0] x0, input int n);
    for (int i = 0; i < n + 3; i++) begin
      @(posedge clk); #1;
      if (i < n) begin
        bus.video_on = 1'b1;
        bus.x        = x0 + 10'(i);
      end else begin
        bus.video_on = 1'b0;
      end
      @(negedge clk);
      if (i >= 1 && i - 1 < n && exp_m[i-1]) begin
        check("rom_x", bus.rom_x, exp_rx[i-1]);
        check("rom_y", bus.rom_y, exp_ry[i-1]);
      end
      if (i >= 3) begin
        check("sprite_on", bus.sprite_on, exp_on[i-3]);
        check("color", bus.color, exp_col[i-3]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.video_on = 1'b0; bus.x = '0; bus.y = '0;
    bus.line_start = 1'b0; bus.line_y = '0; bus.oam_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_on", bus.sprite_on, 0);
    check("rst_color", bus.color, 0);
    check("rst_rom_x", bus.rom_x, 0);
    check("rst_rom_y", bus.rom_y, 0);
    check("rst_ovf", bus.line_overflow, 0);
    check("rst_busy", bus.scan_busy, 0);
    rst = 1'b0;

    // single sprite: pos (100,50), tile (1,2), line 53 -> row 19, rom_x 8..15
    set_oam(0, mk(1, 100, 50, 0, 0, 1, 2));
    pulse_start(53);
    wait_scan();
    for (int k = 0; k < 12; k++) set_exp(k, (k >= 2 && k <= 9), 8 + k - 2, 19);
    run_px(98, 12);

    // priority: entry 2 (tile 2,1) beats entry 5 (tile 3,3); transparent pixel at x=40
    bus.oam_data = '0;
    set_oam(2, mk(1, 36, 20, 0, 0, 2, 1));
    set_oam(5, mk(1, 38, 20, 0, 0, 3, 3));
    trans_en = 1'b1; trans_rx = 10'd20; trans_ry = 10'd8;
    pulse_start(20);
    wait_scan();
    set_exp(0, 1, 19, 8); set_exp(1, 1, 20, 8); set_exp(2, 1, 21, 8);
    set_exp(3, 1, 22, 8); set_exp(4, 1, 23, 8); set_exp(5, 1, 30, 24);
    set_exp(6, 1, 31, 24);
    check("trans_exp_off", {31'd0, exp_on[1]}, 0);
    run_px(39, 7);
    trans_en = 1'b0;
    set_exp(0, 1, 20, 8);
    run_px(40, 1);

    // overflow: six sprites on line 10, only entries 0..3 get slots
    bus.oam_data = '0;
    for (int i = 0; i < 6; i++) set_oam(i, mk(1, 100 + 20 * i, 10, 0, 0, 0, 0));
    pulse_start(10);
    wait_scan();
    check("ovf_set", bus.line_overflow, 1);
    for (int i = 0; i < 6; i++) begin
      set_exp(0, (i < 4), 1, 0);
      run_px(10'(101 + 20 * i), 1);
    end
    for (int i = 2; i < 6; i++) set_oam(i, 32'd0);
    pulse_start(10);
    wait_scan();
    check("ovf_clr", bus.line_overflow, 0);

    // flip: hflip+vflip tile (0,0) -> rom_y 7, rom_x 7 down to 0
    bus.oam_data = '0;
    set_oam(0, mk(1, 200, 30, 1, 1, 0, 0));
    pulse_start(30);
    wait_scan();
    for (int k = 0; k < 8; k++) set_exp(k, 1, 7 - k, 7);
    run_px(200, 8);

    // right edge: pos_x 1020 drawn up to 1023, nothing at 0..4
    bus.oam_data = '0;
    set_oam(0, mk(1, 1020, 5, 0, 0, 0, 0));
    pulse_start(5);
    wait_scan();
    set_exp(0, 1, 2, 0); set_exp(1, 1, 3, 0);
    for (int k = 2; k < 7; k++) set_exp(k, 0, 0, 0);
    run_px(1022, 7);
    // line above the sprite: no hit
    pulse_start(2);
    wait_scan();
    for (int k = 0; k < 4; k++) set_exp(k, 0, 0, 0);
    run_px(1020, 4);

    // abort at index 7, restart with a line that hits
    bus.oam_data = '0;
    set_oam(0, mk(1, 300, 40, 0, 0, 0, 0));
    pulse_start(0);
    repeat (6) @(posedge clk);
    #1;
    pulse_start(40);
    wait_scan();
    set_exp(0, 1, 0, 0);
    run_px(300, 1);

    // reset mid-sprite
    bus.oam_data = '0;
    set_oam(0, mk(1, 100, 50, 0, 0, 1, 2));
    pulse_start(53);
    wait_scan();
    @(posedge clk); #1; bus.video_on = 1'b1; bus.x = 10'd100;
    @(posedge clk); #1; bus.x = 10'd101;
    @(posedge clk); #1; bus.x = 10'd102;
    @(posedge clk); #1; bus.x = 10'd103;
    @(negedge clk);
    check("pre_rst_on", bus.sprite_on, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_on", bus.sprite_on, 0);
    check("mid_rst_color", bus.color, 0);
    check("mid_rst_rom_x", bus.rom_x, 0);
    check("mid_rst_busy", bus.scan_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bus.x = 10'(104 + k);
      @(negedge clk);
      check("post_rst_on", bus.sprite_on, 0);
    end
    bus.video_on = 1'b0;
    pulse_start(53);
    wait_scan();
    set_exp(0, 1, 8, 19);
    run_px(100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Parametrised scanline sprite engine, successor to the fixed 16-entry bullet renderer. It sits between the OAM register file and the pixel mux. During horizontal blanking it scans OAM once and latches up to MAX_PER_LINE visible sprites for the coming line. During active video it resolves priority, horizontal/vertical flip and transparency against an external synchronous sprite ROM, and emits a registered `sprite_on`/`color` at a fixed latency.

## Interface
- OAM_DEPTH, 16, number of OAM entries; any value ≥1.
- MAX_PER_LINE, 4, slot registers per line; 1..OAM_DEPTH.
- TILE_WIDTH, 8, sprite width in pixels; power of two, ≤64.
- TILE_HEIGHT, 8, sprite height in pixels; power of two, ≤64.
- TRANSPARENT, 12'hF0F, ROM colour treated as "no pixel".
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- video_on  in  1  active-video qualifier for x/y.
- x, y  in  10 each  current pixel coordinate.
- line_start  in  1  one-cycle pulse in hblank requesting a scan for line `line_y`.
- line_y  in  10  line to be drawn next; sampled with line_start.
- oam_data  in  32*OAM_DEPTH  flat OAM; entry i = bits [32i+31:32i]. Field layout:
  - [28] enable
  - [27:18] pos_x
  - [17:8] pos_y
  - [7] hflip
  - [6] vflip
  - [5:3] tile_u (ROM column index)
  - [2:0] tile_v (ROM row index)
- rom_x, rom_y  out  10 each  ROM address, registered.
- rom_color  in  12  ROM data, valid exactly one clock after rom_x/rom_y.
- sprite_on  out  1  opaque sprite pixel present.
- color  out  12  pixel colour; 0 when sprite_on=0.
- line_overflow  out  1  more than MAX_PER_LINE sprites hit the last scanned line.
- scan_busy  out  1  high while in SCAN.

## Operation
- FSM states: IDLE, SCAN, READY. Reset → IDLE with all slots invalid and all outputs 0.
- line_start in any state → SCAN. Entering SCAN:
  - latch line_y;
  - clear all slot valid bits;
  - clear the overflow accumulator;
  - index := 0.
- SCAN examines one entry per cycle, index 0..OAM_DEPTH-1.
- An entry hits when enable=1 and 0 ≤ line_y − pos_y < TILE_HEIGHT. Compute with 11-bit signed arithmetic; there is no wrap past 1023.
- On a hit with a free slot, fill the next slot in ascending order with:
  - pos_x, hflip, tile_u;
  - row = tile_v*TILE_HEIGHT + (vflip ? TILE_HEIGHT−1−dy : dy).
- On a hit with all slots full, set the overflow accumulator and drop the entry.
- After index OAM_DEPTH−1 → READY. line_overflow takes the accumulator value and holds until the next scan completes.
- READY, per pixel, with video_on=1:
  - slot s matches when valid and 0 ≤ x − pos_x < TILE_WIDTH (11-bit).
  - Lowest-numbered matching slot wins, which is lowest OAM index.
  - dx = x − pos_x, mirrored when hflip.
  - rom_x = tile_u*TILE_WIDTH + dx; rom_y = row.
- An opaque pixel is a match with rom_color ≠ TRANSPARENT. A transparent winner does NOT fall through to lower-priority slots.
- IDLE, SCAN, or video_on=0: no match. rom_x/rom_y hold their last value.
- oam_data may change at any time; only values sampled during SCAN affect the line.

## Timing
- Scan length is exactly OAM_DEPTH cycles from the cycle after line_start; scan_busy is high for those cycles. Software guarantees hblank ≥ OAM_DEPTH+2 cycles.
- Pixel pipeline, with x/y/video_on sampled at edge 0:
  - edge 1: rom_x/rom_y and the match flag registered;
  - edge 2: ROM data available;
  - edge 3: sprite_on/color registered.
- Total latency is exactly 3 clocks, and the pipeline flows continuously with one pixel per clock.
- line_start during SCAN aborts and restarts the scan from index 0 with the new line_y.
- Reset mid-scan or mid-line returns to IDLE. sprite_on=0 and color=0 from the first edge with reset high. The pipeline is flushed, so no stale pixel appears after release.
- Transition to SCAN while the pipeline holds pixels: in-flight pixels complete with the old data. New pixels see no match.

## Test plan
- Single sprite: entry 0 = enable, pos (100,50), tile (1,2), no flip; line_start with line_y=53, then x=100..107. Required: rom_x=8..15, rom_y=19, sprite_on asserts 3 clocks after x=100 and stays high 8 cycles.
- Priority/transparency: entries 2 and 5 overlap at x=40. ROM returns TRANSPARENT for entry 2's pixel. Required: sprite_on=0 at that pixel (no fall-through); with an opaque colour, color equals entry 2's data.
- Overflow: 6 enabled sprites on line 10, MAX_PER_LINE=4. Required: indices 0–3 drawn, 4–5 absent; line_overflow=1 after the scan. The next line with 2 sprites gives line_overflow=0.
- Flip: hflip=1, vflip=1, tile (0,0), line_y=pos_y. Required: rom_y=7; rom_x runs 7 down to 0 across the sprite.
- Boundaries: pos_x=1020, x=1023, sprite drawn with no wrap to x=0..4. pos_y=5 with line_y=2 gives no hit. line_start at index 7 of a scan gives scan_busy for a further 16 cycles.
- Reset: assert reset in READY mid-sprite. Required: sprite_on=0 next edge, FSM IDLE, and no pixel output until a new scan completes.
